// File: rtl/alarm_countdown_timer.sv
// Countdown timer that latches an interval select, samples the store's duration and
// counts it down in seconds. Optional pause input is enabled with `define TIMER_PAUSE_EN.
module alarm_countdown_timer #(
  parameter int unsigned CLK_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval_sel,
  input  logic       cancel,
`ifdef TIMER_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       expired
);

  localparam int unsigned PresW = $clog2(CLK_PER_SEC);
  localparam logic [PresW-1:0] PresMax = PresW'(CLK_PER_SEC - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StCount  = 2'd2;
  localparam logic [1:0] StExpire = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       interval_q, interval_d;
  logic [3:0]       rem_q, rem_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             go;
  logic             hold;

  // Cancel always beats start.
  assign go = start_timer & ~cancel;

`ifdef TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    rem_d      = rem_q;
    presc_d    = presc_q;
    case (state_q)
      StIdle: begin
        if (go) begin
          interval_d = interval_sel;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (cancel) begin
          rem_d   = 4'd0;
          presc_d = '0;
          state_d = StIdle;
        end else if (go) begin
          // Restart: stay in LOAD so the new select's value is sampled next cycle.
          interval_d = interval_sel;
        end else begin
          rem_d   = value;
          presc_d = '0;
          state_d = (value == 4'd0) ? StExpire : StCount;
        end
      end
      StCount: begin
        if (cancel) begin
          rem_d   = 4'd0;
          presc_d = '0;
          state_d = StIdle;
        end else if (go) begin
          interval_d = interval_sel;
          state_d    = StLoad;
        end else if (!hold) begin
          if (presc_q == PresMax) begin
            presc_d = '0;
            if (rem_q <= 4'd1) begin
              rem_d   = 4'd0;
              state_d = StExpire;
            end else begin
              rem_d = rem_q - 4'd1;
            end
          end else begin
            presc_d = presc_q + PresW'(1);
          end
        end
      end
      StExpire: begin
        if (cancel) begin
          rem_d   = 4'd0;
          presc_d = '0;
          state_d = StIdle;
        end else if (go) begin
          interval_d = interval_sel;
          state_d    = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      interval_q <= 2'd0;
      rem_q      <= 4'd0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      rem_q      <= rem_d;
      presc_q    <= presc_d;
    end
  end

  assign interval  = interval_q;
  assign remaining = rem_q;
  assign busy      = (state_q != StIdle);
  assign expired   = (state_q == StExpire);

endmodule

// File: tb/tb_alarm_countdown_timer.sv
// Self-checking bench for alarm_countdown_timer: directed scenarios plus randomized
// traffic against a cycle-count reference model.
module tb_alarm_countdown_timer;

  localparam int CPS = 4;
`ifdef TIMER_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic       cancel;
  logic       pause;
  logic [3:0] value;
  logic [1:0] interval;
  logic [3:0] remaining;
  logic       busy;
  logic       expired;

  logic [3:0] store [4];
  assign value = store[interval];

  alarm_countdown_timer #(
    .CLK_PER_SEC(CPS)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start_timer (start_timer),
    .interval_sel(interval_sel),
    .cancel      (cancel),
`ifdef TIMER_PAUSE_EN
    .pause       (pause),
`endif
    .value       (value),
    .interval    (interval),
    .remaining   (remaining),
    .busy        (busy),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a countdown of raw clock cycles; seconds shown = ceil(cycles/CPS).
  int         m_phase;  // 0 idle, 1 load, 2 counting, 3 expire pulse
  int         m_left;
  int         m_rem;
  logic [1:0] m_int;

  task automatic model_step();
    bit go;
    go = start_timer && !cancel;
    if (reset) begin
      m_phase = 0; m_int = 2'd0; m_rem = 0; m_left = 0;
      return;
    end
    if (m_phase != 0 && cancel) begin
      m_phase = 0; m_rem = 0; m_left = 0;
      return;
    end
    case (m_phase)
      0: if (go) begin m_int = interval_sel; m_phase = 1; end
      1: begin
        if (go) m_int = interval_sel;
        else begin
          m_rem   = int'(store[m_int]);
          m_left  = m_rem * CPS;
          m_phase = (m_rem == 0) ? 3 : 2;
        end
      end
      2: begin
        if (go) begin m_int = interval_sel; m_phase = 1; end
        else if (!(PauseEn && pause)) begin
          m_left--;
          m_rem = (m_left + CPS - 1) / CPS;
          if (m_left == 0) m_phase = 3;
        end
      end
      default: begin
        if (go) begin m_int = interval_sel; m_phase = 1; end
        else m_phase = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("interval", int'(interval), int'(m_int));
    check("remaining", int'(remaining), m_rem);
    check("busy", int'(busy), int'(m_phase != 0));
    check("expired", int'(expired), int'(m_phase == 3));
  endtask

  // Inputs of cycle c are applied before tick(), which then shows cycle c+1.
  task automatic watch(input int from, input int upto, inout int first, inout int n);
    for (int c = from; c < upto; c++) begin
      tick();
      if (expired) begin
        n++;
        if (first < 0) first = c + 1;
      end
    end
  endtask

  task automatic store_defaults();
    store[0] = 4'd6; store[1] = 4'd8; store[2] = 4'd15; store[3] = 4'd10;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic basic_run(input string tag);
    int first = -1;
    int n = 0;
    start_timer = 1'b1; interval_sel = 2'd0;
    tick();
    check({tag, "_interval_c1"}, int'(interval), 0);
    start_timer = 1'b0;
    watch(1, 2, first, n);
    check({tag, "_remaining_c2"}, int'(remaining), 6);
    watch(2, 40, first, n);
    check({tag, "_exp_cycle"}, first, 26);
    check({tag, "_exp_count"}, n, 1);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int first;
    int n;
    reset = 1'b0; start_timer = 1'b0; interval_sel = 2'd0; cancel = 1'b0; pause = 1'b0;
    store_defaults();
    m_phase = 0; m_left = 0; m_rem = 0; m_int = 2'd0;
    @(negedge clk);
    do_reset();
    check("reset_busy", int'(busy), 0);
    check("reset_remaining", int'(remaining), 0);

    // 1: plain countdown of the arm delay
    basic_run("t1");

    // 2: zero duration expires straight out of LOAD
    store[3] = 4'd0;
    first = -1; n = 0;
    start_timer = 1'b1; interval_sel = 2'd3;
    tick();
    start_timer = 1'b0;
    watch(1, 6, first, n);
    check("t2_exp_cycle", first, 2);
    check("t2_exp_count", n, 1);
    check("t2_remaining", int'(remaining), 0);
    store_defaults();

    // 3: cancel mid-count, then start+cancel together in IDLE
    first = -1; n = 0;
    start_timer = 1'b1; interval_sel = 2'd2;
    tick();
    start_timer = 1'b0;
    watch(1, 10, first, n);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t3_busy_c11", int'(busy), 0);
    check("t3_remaining_c11", int'(remaining), 0);
    watch(11, 80, first, n);
    check("t3_exp_count", n, 0);
    start_timer = 1'b1; cancel = 1'b1;
    tick();
    start_timer = 1'b0; cancel = 1'b0;
    check("t3_start_cancel_idle", int'(busy), 0);

    // 4: restart with a different select during COUNT
    first = -1; n = 0;
    start_timer = 1'b1; interval_sel = 2'd1;
    tick();
    start_timer = 1'b0;
    watch(1, 9, first, n);
    start_timer = 1'b1; interval_sel = 2'd0;
    watch(9, 10, first, n);
    start_timer = 1'b0;
    check("t4_busy_c10", int'(busy), 1);
    check("t4_interval_c10", int'(interval), 0);
    watch(10, 11, first, n);
    check("t4_remaining_c11", int'(remaining), 6);
    watch(11, 50, first, n);
    check("t4_exp_cycle", first, 35);
    check("t4_exp_count", n, 1);

    // 5: reset in the middle of a countdown
    first = -1; n = 0;
    start_timer = 1'b1; interval_sel = 2'd2;
    tick();
    start_timer = 1'b0;
    watch(1, 6, first, n);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_interval", int'(interval), 0);
    check("t5_remaining", int'(remaining), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_expired", int'(expired), 0);
    basic_run("t5");

    // 6: pause stretches the countdown by the paused cycles
    if (PauseEn) begin
      first = -1; n = 0;
      start_timer = 1'b1; interval_sel = 2'd0;
      tick();
      start_timer = 1'b0;
      watch(1, 5, first, n);
      pause = 1'b1;
      watch(5, 15, first, n);
      check("t6_remaining_paused", int'(remaining), 6);
      pause = 1'b0;
      watch(15, 45, first, n);
      check("t6_exp_cycle", first, 36);
      check("t6_exp_count", n, 1);
    end

    // Randomized traffic, including store reprogramming at arbitrary times
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      start_timer  = ($urandom_range(0, 9) == 0);
      cancel       = ($urandom_range(0, 19) == 0);
      interval_sel = 2'($urandom_range(0, 3));
      pause        = PauseEn && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0)
        store[$urandom_range(0, 3)] = 4'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0; start_timer = 1'b0; cancel = 1'b0; pause = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
